// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a bitstream into NUM_CHAINS parallel configuration chains.
//
// One beat carries one bit per chain. Accepted beats are registered onto ccff_head and
// shifted into the fabric one cycle later. After the load, the chains can be rotated
// once (tail fed back to head) so that their contents can be read back and CRC-checked
// against the CRC of the loaded bits without disturbing them.
//
// Ports:
//   prog_clk       configuration clock, all state on the rising edge
//   prog_reset     asynchronous active-low reset
//   start          one-cycle pulse, begins a load when idle
//   abort          level, returns to idle from any busy state and flags an error
//   bs_valid       bitstream beat valid
//   bs_data        one bit per chain (bit i feeds chain i)
//   bs_ready       beat accepted when bs_valid & bs_ready
//   ccff_head      chain head bits to the fabric
//   ccff_tail      chain tail bits from the fabric
//   shift_en       fabric chains shift on prog_clk edges where this is high
//   config_enable  high while the chains are being written or read back
//   busy           high whenever not idle
//   done           one-cycle pulse at the end of a completed sequence
//   pass           result qualifier for done, held until the next start
//   error          sticky CRC-mismatch / abort flag, cleared by start
module ccff_chain_loader #(
    parameter int unsigned NUM_CHAINS = 8,
    parameter int unsigned CHAIN_LEN  = 1024,
    parameter bit          VERIFY_EN  = 1'b1,
    parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  bs_valid,
    input  logic [NUM_CHAINS-1:0] bs_data,
    output logic                  bs_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  shift_en,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  error
);

    localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [15:0]      CrcInit  = 16'hFFFF;
    localparam logic [15:0]      CrcPoly  = 16'h1021;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StVerify,
        StCheck,
        StDone
    } state_e;

    state_e                state_q;
    logic [NUM_CHAINS-1:0] head_q;
    logic                  shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [15:0]           crc_load_q [NUM_CHAINS];
    logic [15:0]           crc_rb_q   [NUM_CHAINS];
    logic                  done_q;
    logic                  pass_q;
    logic                  error_q;

    logic                  handshake;
    logic                  crc_match;

    // CRC-16-CCITT, one message bit per call, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CrcPoly : 16'h0000);
    endfunction

    // abort gates ready so a beat offered alongside abort is never seen as accepted.
    assign bs_ready  = (state_q == StLoad) && !abort;
    assign handshake = bs_valid && bs_ready;

    always_comb begin
        crc_match = 1'b1;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            if (crc_load_q[i] != crc_rb_q[i]) begin
                crc_match = 1'b0;
            end
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q <= StIdle;
            head_q  <= '0;
            shift_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                crc_load_q[i] <= CrcInit;
                crc_rb_q[i]   <= CrcInit;
            end
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q <= StIdle;
                shift_q <= 1'b0;
                error_q <= 1'b1;
                pass_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            state_q <= StLoad;
                            shift_q <= 1'b0;
                            cnt_q   <= '0;
                            error_q <= 1'b0;
                            pass_q  <= 1'b0;
                            for (int i = 0; i < NUM_CHAINS; i++) begin
                                crc_load_q[i] <= CrcInit;
                                crc_rb_q[i]   <= CrcInit;
                            end
                        end
                    end
                    StLoad: begin
                        if (handshake) begin
                            head_q  <= bs_data;
                            shift_q <= 1'b1;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            for (int i = 0; i < NUM_CHAINS; i++) begin
                                crc_load_q[i] <= crc16_step(crc_load_q[i], bs_data[i]);
                            end
                            if (cnt_q == LastCnt) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            shift_q <= 1'b0;
                        end
                    end
                    StDrain: begin
                        // The last beat shifts in during this cycle via shift_q.
                        shift_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= VERIFY_EN ? StVerify : StDone;
                    end
                    StVerify: begin
                        for (int i = 0; i < NUM_CHAINS; i++) begin
                            crc_rb_q[i] <= crc16_step(crc_rb_q[i], ccff_tail[i]);
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LastCnt) begin
                            state_q <= StCheck;
                        end
                    end
                    StCheck: begin
                        pass_q  <= crc_match;
                        error_q <= error_q | ~crc_match;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    StDone: begin
                        pass_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // During readback each chain rotates through itself, leaving its contents intact.
    always_comb begin
        ccff_head     = '0;
        shift_en      = 1'b0;
        config_enable = 1'b0;
        case (state_q)
            StLoad, StDrain: begin
                ccff_head     = head_q;
                shift_en      = shift_q;
                config_enable = 1'b1;
            end
            StVerify: begin
                ccff_head     = ccff_tail;
                shift_en      = 1'b1;
                config_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != StIdle);
    assign done  = done_q;
    assign pass  = pass_q;
    assign error = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    localparam int NC = 8;
    localparam int L  = 8;

    logic          prog_clk   = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start      = 1'b0;
    logic          start_nv   = 1'b0;
    logic          abort      = 1'b0;
    logic          bs_valid   = 1'b0;
    logic [NC-1:0] bs_data    = '0;
    logic [NC-1:0] ccff_tail;
    logic [NC-1:0] ccff_tail_nv;

    logic          bs_ready, shift_en, config_enable, busy, done, pass, error;
    logic [NC-1:0] ccff_head;
    logic          bs_ready_nv, shift_en_nv, config_enable_nv, busy_nv, done_nv, pass_nv, error_nv;
    logic [NC-1:0] ccff_head_nv;

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .VERIFY_EN(1'b1)) dut (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready), .ccff_head(ccff_head),
        .ccff_tail(ccff_tail), .shift_en(shift_en), .config_enable(config_enable),
        .busy(busy), .done(done), .pass(pass), .error(error)
    );

    ccff_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(L), .VERIFY_EN(1'b0)) dut_nv (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_nv), .abort(abort),
        .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready_nv), .ccff_head(ccff_head_nv),
        .ccff_tail(ccff_tail_nv), .shift_en(shift_en_nv), .config_enable(config_enable_nv),
        .busy(busy_nv), .done(done_nv), .pass(pass_nv), .error(error_nv)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        logic [16:0] t;
        t = {c, 1'b0};
        if (c[15] ^ b) t[15:0] = t[15:0] ^ 16'h1021;
        return t[15:0];
    endfunction

    // Fabric: each chain is an L-deep shift register, oldest bit at the tail.
    logic [NC-1:0] fab[$];
    logic [NC-1:0] fab_tail;
    logic [NC-1:0] inj_mask = '0;
    int            shift_cnt = 0;
    int            shift_cnt_nv = 0;
    assign ccff_tail    = fab_tail ^ inj_mask;
    assign ccff_tail_nv = 8'h5A;

    always @(posedge prog_clk) begin
        if (shift_en) begin
            fab.push_back(ccff_head);
            void'(fab.pop_front());
            fab_tail <= fab[0];
            shift_cnt++;
        end
        if (shift_en_nv) shift_cnt_nv++;
    end

    // Reference model of the VERIFY_EN=1 loader, tracked in terms of edges and beat counts.
    int            cyc = 0;
    bit            act = 0;
    int            hs = 0;
    int            t_last = -100;
    int            last_hs = -100;
    bit            m_err = 0, m_pass = 0, m_done = 0;
    logic [NC-1:0] m_beats[$];
    logic [NC-1:0] m_tails[$];
    bit            chk_en = 0;

    function automatic bit crcs_match();
        logic [15:0] a, b;
        if (m_tails.size() != L || m_beats.size() != L) return 1'b0;
        for (int j = 0; j < NC; j++) begin
            a = 16'hFFFF;
            b = 16'hFFFF;
            for (int k = 0; k < L; k++) begin
                a = crc_upd(a, m_beats[k][j]);
                b = crc_upd(b, m_tails[k][j]);
            end
            if (a != b) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge prog_clk) begin
        int prev_a;
        prev_a = cyc - t_last;
        cyc++;
        m_done = 0;
        if (!prog_reset) begin
            act = 0; hs = 0; m_err = 0; m_pass = 0;
        end else if (act) begin
            if (abort) begin
                act = 0; m_err = 1; m_pass = 0;
            end else if (hs < L) begin
                if (bs_valid) begin
                    m_beats.push_back(bs_data);
                    hs++;
                    last_hs = cyc;
                    if (hs == L) t_last = cyc;
                end
            end else begin
                if (prev_a >= 1 && prev_a <= L) m_tails.push_back(ccff_tail);
                if (cyc - t_last == L + 2) begin
                    act = 0; m_done = 1;
                    m_pass = crcs_match();
                    m_err = m_err | !m_pass;
                end
            end
        end else if (start && !abort) begin
            act = 1; hs = 0; m_err = 0; m_pass = 0;
            m_beats.delete();
            m_tails.delete();
        end
    end

    always @(negedge prog_clk) begin
        logic [6:0] want, got;
        bit ld, dr, ve, sh;
        int a;
        if (chk_en) begin
            a  = cyc - t_last;
            ld = act && hs < L;
            dr = act && hs == L && a == 0;
            ve = act && hs == L && a >= 1 && a <= L;
            sh = (act && last_hs == cyc) || ve;
            if (!prog_reset) want = '0;
            else want = {act, ld | dr | ve, ld && !abort, sh, m_done, m_pass, m_err};
            got = {busy, config_enable, bs_ready, shift_en, done, pass, error};
            chk("ctrl{busy,cfg,ready,shift,done,pass,err}", 32'(got), 32'(want));
            if (!prog_reset || !(ld | dr | ve)) chk("head_idle", ccff_head, '0);
            else if (ve) chk("head_verify", ccff_head, ccff_tail);
            else if (sh) chk("head_load", ccff_head, m_beats[m_beats.size()-1]);
        end
    end

    logic [NC-1:0] tx[L];

    task automatic do_start(input bit nv);
        if (nv) start_nv = 1'b1; else start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        start_nv = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
    task automatic send(input int n, input int mode, input bit nv, output int last_edge);
        int i = 0;
        int budget = 200;
        bit v, r;
        bit tog = 1'b1;
        last_edge = -1;
        while (i < n && budget > 0) begin
            budget--;
            case (mode)
                0: v = 1'b1;
                1: begin v = tog; tog = !tog; end
                default: v = 1'($urandom % 2);
            endcase
            bs_valid = v;
            bs_data  = v ? tx[i] : NC'($urandom);
            @(negedge prog_clk);
            r = nv ? bs_ready_nv : bs_ready;
            @(posedge prog_clk); #1;
            if (v && r) begin
                i++;
                last_edge = cyc;
            end
        end
        bs_valid = 1'b0;
        chk("beats_accepted", i, n);
    endtask

    task automatic wait_done(input bit nv, output int done_edge);
        int budget = 40;
        done_edge = -1;
        while (budget > 0) begin
            budget--;
            @(negedge prog_clk);
            if (nv ? done_nv : done) begin
                done_edge = cyc;
                break;
            end
        end
        chk("done_seen", 32'(done_edge >= 0), 1);
        @(posedge prog_clk); #1;
    endtask

    task automatic full_run(input int mode, output int delay);
        int le, de, sc;
        sc = shift_cnt;
        do_start(1'b0);
        send(L, mode, 1'b0, le);
        wait_done(1'b0, de);
        delay = de - le;
        chk("shift_pulses", shift_cnt - sc, 2 * L);
    endtask

    initial begin
        string s;
        logic [15:0] c;
        int d, le, de, sc, nd;
        logic [NC-1:0] inj;

        for (int i = 0; i < L; i++) fab.push_back(NC'($urandom));
        fab_tail = fab[0];
        #1 prog_reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b1;

        // Pin the CRC model: CRC-16/CCITT-FALSE("123456789") = 0x29B1.
        s = "123456789";
        c = 16'hFFFF;
        for (int i = 0; i < s.len(); i++) begin
            byte ch;
            ch = s[i];
            for (int b = 7; b >= 0; b--) c = crc_upd(c, ch[b]);
        end
        chk("crc_model_ref", c, 16'h29B1);

        // 1: walking-one beats, back-to-back
        for (int i = 0; i < L; i++) tx[i] = NC'(1) << i;
        full_run(0, d);
        chk("t1_done_delay", d, 10);
        chk("t1_pass", pass, 1);
        chk("t1_error", error, 0);
        for (int i = 0; i < L; i++) chk("t1_fabric", fab[i], NC'(1) << i);

        // 2: same stream, valid toggling
        full_run(1, d);
        chk("t2_pass", pass, 1);
        for (int i = 0; i < L; i++) chk("t2_fabric", fab[i], NC'(1) << i);

        // 3: chain 3 tail corrupted during readback
        inj_mask = 8'h08;
        full_run(0, d);
        inj_mask = '0;
        chk("t3_pass", pass, 0);
        chk("t3_error", error, 1);
        for (int i = 0; i < L; i++) chk("t3_fabric", fab[i], (NC'(1) << i) ^ 8'h08);

        // 4: abort after the 4th handshake
        do_start(1'b0);
        send(4, 0, 1'b0, le);
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_shift", shift_en, 0);
        chk("t4_error", error, 1);
        nd = 0;
        repeat (15) begin
            @(negedge prog_clk);
            if (done) nd++;
        end
        @(posedge prog_clk); #1;
        chk("t4_no_done", nd, 0);
        do_start(1'b0);
        chk("t4_error_cleared", error, 0);
        send(L, 0, 1'b0, le);
        wait_done(1'b0, de);
        chk("t4_reload_pass", pass, 1);

        // 5: VERIFY_EN=0 instance
        for (int i = 0; i < L; i++) tx[i] = 8'hA5;
        sc = shift_cnt_nv;
        do_start(1'b1);
        send(L, 0, 1'b1, le);
        wait_done(1'b1, de);
        chk("t5_done_delay", de - le, 2);
        chk("t5_pass", pass_nv, 1);
        chk("t5_shift_pulses", shift_cnt_nv - sc, L);
        chk("t5_head_idle", ccff_head_nv, 0);

        // 6: reset in the middle of readback
        for (int i = 0; i < L; i++) tx[i] = NC'($urandom);
        do_start(1'b0);
        send(L, 0, 1'b0, le);
        repeat (3) @(posedge prog_clk);
        #1 prog_reset = 1'b0;
        #1;
        chk("t6_outputs_reset",
            32'({bs_ready, ccff_head, shift_en, config_enable, busy, done, pass, error}), 0);
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b1;
        full_run(2, d);
        chk("t6_pass", pass, 1);

        // Random loads, some with a corrupted chain during readback
        repeat (6) begin
            for (int i = 0; i < L; i++) tx[i] = NC'($urandom);
            inj = ($urandom % 2) ? (NC'(1) << ($urandom % NC)) : '0;
            inj_mask = inj;
            full_run(2, d);
            inj_mask = '0;
            chk("rand_pass", pass, 32'(inj == '0));
            chk("rand_done_delay", d, 10);
        end

        #20;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
